// File: rtl/atm_menu_ctrl.sv
// Menu sequencer for the crypto ATM front panel.
// Conditions the four push-buttons (synchronize, debounce, edge-detect),
// tracks the selected screen, runs the two-step select/confirm sequence,
// issues a one-cycle action strobe, and falls back to screen 0 when idle.
//
// Handshake: action_go is a single-cycle strobe with no back-pressure;
// action_id is valid only in the cycle action_go is high.
//
// Button index order used internally: 0=up, 1=down, 2=left, 3=right.
module atm_menu_ctrl #(
   parameter int unsigned     DEBOUNCE_CYCLES = 1000000,
   parameter longint unsigned TIMEOUT_CYCLES  = 64'd3000000000,
   parameter int unsigned     CONFIRM_CYCLES  = 500000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       BTNU,
   input  logic       BTND,
   input  logic       BTNL,
   input  logic       BTNR,
   output logic [1:0] screen_sel,
   output logic [3:0] screen_rst,
   output logic       confirm_pending,
   output logic       action_go,
   output logic [1:0] action_id,
   output logic [1:0] dbg_state_o
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int CW = $clog2(CONFIRM_CYCLES + 1);

   localparam int B_U = 0;
   localparam int B_D = 1;
   localparam int B_L = 2;
   localparam int B_R = 3;

   typedef enum logic [1:0] {
      BROWSE  = 2'd0,
      CONFIRM = 2'd1,
      COMMIT  = 2'd2
   } state_t;

   // ---------------------------------------------------------------------
   // Button conditioning
   // ---------------------------------------------------------------------
   logic [3:0]    btn_raw;
   logic [3:0]    sync1_q;
   logic [3:0]    sync2_q;
   logic [3:0]    level_q;
   logic [3:0]    level_d;
   logic [3:0]    level_prev_q;
   logic [DW-1:0] db_cnt_q [4];
   logic [DW-1:0] db_cnt_d [4];
   logic [3:0]    press;

   assign btn_raw = {BTNR, BTNL, BTND, BTNU};

   // Synchronizer, debounce counters and accepted-level history.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q      <= '0;
         sync2_q      <= '0;
         level_q      <= '0;
         level_prev_q <= '0;
         for (int i = 0; i < 4; i++) begin
            db_cnt_q[i] <= '0;
         end
      end else begin
         sync1_q      <= btn_raw;
         sync2_q      <= sync1_q;
         level_q      <= level_d;
         level_prev_q <= level_q;
         for (int i = 0; i < 4; i++) begin
            db_cnt_q[i] <= db_cnt_d[i];
         end
      end
   end

   // A differing synchronized level must persist DEBOUNCE_CYCLES samples;
   // any return to the accepted level reloads the counter.
   always_comb begin
      level_d = level_q;
      for (int i = 0; i < 4; i++) begin
         db_cnt_d[i] = '0;
         if (sync2_q[i] != level_q[i]) begin
            if (db_cnt_q[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
               level_d[i] = sync2_q[i];
            end else begin
               db_cnt_d[i] = db_cnt_q[i] + DW'(1);
            end
         end
      end
   end

   assign press = level_q & ~level_prev_q;

   // ---------------------------------------------------------------------
   // Inactivity and confirm-window timers
   // ---------------------------------------------------------------------
   state_t        state_q;
   state_t        state_d;
   logic [TW-1:0] tmo_cnt_q;
   logic [TW-1:0] tmo_cnt_d;
   logic [CW-1:0] conf_cnt_q;
   logic [CW-1:0] conf_cnt_d;
   logic          any_press;
   logic          timeout_hit;
   logic          conf_expired;

   assign any_press    = |press;
   // A press in the same cycle wins over the timeout.
   assign timeout_hit  = (tmo_cnt_q == TW'(TIMEOUT_CYCLES)) && !any_press;
   assign conf_expired = (conf_cnt_q == CW'(CONFIRM_CYCLES - 1));

   // Timer next-state: inactivity saturates, confirm window counts only in CONFIRM.
   always_comb begin
      tmo_cnt_d  = tmo_cnt_q;
      conf_cnt_d = '0;
      if (any_press) begin
         tmo_cnt_d = '0;
      end else if (tmo_cnt_q != TW'(TIMEOUT_CYCLES)) begin
         tmo_cnt_d = tmo_cnt_q + TW'(1);
      end
      if (state_q == CONFIRM) begin
         conf_cnt_d = conf_cnt_q + CW'(1);
      end
   end

   // ---------------------------------------------------------------------
   // Menu FSM
   // ---------------------------------------------------------------------
   logic [1:0] sel_q;
   logic [1:0] sel_d;
   logic [1:0] act_id_q;
   logic [1:0] act_id_d;
   logic [3:0] screen_rst_q;
   logic [3:0] screen_rst_d;
   logic       pending_q;
   logic       go_q;
   logic       ud_clash;

   assign ud_clash = press[B_U] & press[B_D];

   // Next state, next screen and latched action id.
   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      act_id_d = act_id_q;
      case (state_q)
         BROWSE: begin
            if (timeout_hit) begin
               sel_d = 2'd0;
            end else if (press[B_L]) begin
               sel_d = 2'd0;
            end else if (press[B_R]) begin
               state_d  = CONFIRM;
               act_id_d = sel_q;
            end else if (!ud_clash && press[B_D]) begin
               sel_d = sel_q + 2'd1;
            end else if (!ud_clash && press[B_U]) begin
               sel_d = sel_q - 2'd1;
            end
         end
         CONFIRM: begin
            if (timeout_hit) begin
               state_d = BROWSE;
               sel_d   = 2'd0;
            end else if (press[B_L]) begin
               state_d = BROWSE;
            end else if (press[B_R]) begin
               state_d = COMMIT;
            end else if (conf_expired) begin
               state_d = BROWSE;
            end
         end
         COMMIT: begin
            state_d = BROWSE;
         end
         default: begin
            state_d = BROWSE;
         end
      endcase
   end

   // A screen change holds every scroller in restart for one cycle so the
   // newly selected one starts from its first character.
   always_comb begin
      screen_rst_d = ~(4'b0001 << sel_d);
      if (sel_d != sel_q) begin
         screen_rst_d = 4'b1111;
      end
   end

   // State and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= BROWSE;
         sel_q        <= 2'd0;
         act_id_q     <= 2'd0;
         screen_rst_q <= 4'b1111;
         pending_q    <= 1'b0;
         go_q         <= 1'b0;
         tmo_cnt_q    <= '0;
         conf_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         sel_q        <= sel_d;
         act_id_q     <= act_id_d;
         screen_rst_q <= screen_rst_d;
         pending_q    <= (state_d == CONFIRM);
         go_q         <= (state_d == COMMIT);
         tmo_cnt_q    <= tmo_cnt_d;
         conf_cnt_q   <= conf_cnt_d;
      end
   end

   assign screen_sel      = sel_q;
   assign screen_rst      = screen_rst_q;
   assign confirm_pending = pending_q;
   assign action_go       = go_q;
   assign action_id       = act_id_q;
   assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_atm_menu_ctrl.sv
// Bench for atm_menu_ctrl: directed button sequences; expected screen
// changes and actions are queued by the driver and consumed by a monitor.
module tb_atm_menu_ctrl;

   localparam logic [1:0] ST_BROWSE = 2'd0;

   logic       clk;
   logic       rst_n;
   logic       BTNU, BTND, BTNL, BTNR;
   logic [1:0] screen_sel;
   logic [3:0] screen_rst;
   logic       confirm_pending;
   logic       action_go;
   logic [1:0] action_id;
   logic [1:0] dbg_state;

   int n_checks = 0;
   int n_errors = 0;

   logic [1:0] exp_sel_q[$];
   logic [1:0] exp_act_q[$];

   atm_menu_ctrl #(
      .DEBOUNCE_CYCLES(4),
      .TIMEOUT_CYCLES (200),
      .CONFIRM_CYCLES (50)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .BTNU           (BTNU),
      .BTND           (BTND),
      .BTNL           (BTNL),
      .BTNR           (BTNR),
      .screen_sel     (screen_sel),
      .screen_rst     (screen_rst),
      .confirm_pending(confirm_pending),
      .action_go      (action_go),
      .action_id      (action_id),
      .dbg_state_o    (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- check helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic report;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
   endtask

   // ---------------- driver tasks ----------------
   // mask bit order: 0=U 1=D 2=L 3=R
   task automatic press(input logic [3:0] mask, input int hold, input int gap);
      @(negedge clk);
      {BTNR, BTNL, BTND, BTNU} = mask;
      repeat (hold) @(negedge clk);
      {BTNR, BTNL, BTND, BTNU} = 4'b0000;
      repeat (gap) @(negedge clk);
   endtask

   task automatic press_exp(input logic [3:0] mask, input logic [1:0] exp_sel);
      exp_sel_q.push_back(exp_sel);
      press(mask, 8, 12);
   endtask

   // ---------------- monitor / scoreboard ----------------
   logic [1:0] prev_sel = 2'd0;
   logic       prev_go  = 1'b0;
   logic [3:0] onehot_n;
   logic [1:0] exp_v;

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_sel = 2'd0;
         prev_go  = 1'b0;
      end else begin
         if (screen_sel != prev_sel) begin
            if (exp_sel_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_sel_change: got %0d expected %0d", screen_sel, prev_sel);
            end else begin
               exp_v = exp_sel_q.pop_front();
               check("screen_sel", 32'(screen_sel), 32'(exp_v));
            end
            check("screen_rst_restart", 32'(screen_rst), 32'hF);
         end else begin
            onehot_n = ~(4'b0001 << screen_sel);
            check("screen_rst_steady", 32'(screen_rst), 32'(onehot_n));
         end
         if (action_go) begin
            check("action_go_single", 32'(prev_go), 32'd0);
            if (exp_act_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_action_go: got id %0d expected no strobe", action_id);
            end else begin
               exp_v = exp_act_q.pop_front();
               check("action_id", 32'(action_id), 32'(exp_v));
            end
         end
         prev_sel = screen_sel;
         prev_go  = action_go;
      end
   end

   // ---------------- watchdog ----------------
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      n_errors++;
      report();
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      {BTNR, BTNL, BTND, BTNU} = 4'b0000;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_screen_sel", 32'(screen_sel), 32'd0);
      check("rst_screen_rst", 32'(screen_rst), 32'hF);
      check("rst_pending", 32'(confirm_pending), 32'd0);
      check("rst_action_go", 32'(action_go), 32'd0);
      check("rst_action_id", 32'(action_id), 32'd0);
      #2 rst_n = 1'b1;
      @(negedge clk);
      check("first_cycle_screen_rst", 32'(screen_rst), 32'hE);

      // Four next-screen presses: 1,2,3,0
      press_exp(4'b0010, 2'd1);
      press_exp(4'b0010, 2'd2);
      press_exp(4'b0010, 2'd3);
      press_exp(4'b0010, 2'd0);

      // Up from screen 0 wraps to 3
      press_exp(4'b0001, 2'd3);
      // Short glitch: no change
      press(4'b0010, 2, 20);
      check("glitch_sel", 32'(screen_sel), 32'd3);
      // Long hold: exactly one increment 3 -> 0
      exp_sel_q.push_back(2'd0);
      press(4'b0010, 100, 20);
      check("hold_sel", 32'(screen_sel), 32'd0);

      // Confirm on screen 2
      press_exp(4'b0010, 2'd1);
      press_exp(4'b0010, 2'd2);
      exp_act_q.push_back(2'd2);
      press(4'b1000, 5, 5);
      check("confirm_pending_between", 32'(confirm_pending), 32'd1);
      press(4'b1000, 5, 5);
      repeat (10) @(negedge clk);
      check("after_commit_pending", 32'(confirm_pending), 32'd0);
      check("after_commit_state", 32'(dbg_state), 32'(ST_BROWSE));
      check("after_commit_sel", 32'(screen_sel), 32'd2);
      check("action_consumed", 32'(exp_act_q.size()), 32'd0);

      // Confirm window expiry on screen 1
      press_exp(4'b0001, 2'd1);
      press(4'b1000, 5, 5);
      check("window_pending_early", 32'(confirm_pending), 32'd1);
      repeat (30) @(negedge clk);
      check("window_pending_mid", 32'(confirm_pending), 32'd1);
      repeat (30) @(negedge clk);
      check("window_pending_expired", 32'(confirm_pending), 32'd0);
      check("window_sel", 32'(screen_sel), 32'd1);
      check("window_state", 32'(dbg_state), 32'(ST_BROWSE));

      // Cancel with BTNL
      press(4'b1000, 5, 5);
      check("cancel_pending_before", 32'(confirm_pending), 32'd1);
      press(4'b0100, 5, 5);
      check("cancel_pending_after", 32'(confirm_pending), 32'd0);
      check("cancel_sel", 32'(screen_sel), 32'd1);

      // Up+down together: ignored
      press(4'b0011, 8, 12);
      check("updown_sel", 32'(screen_sel), 32'd1);
      // Left+right together in BROWSE: back to 0, no confirm
      press_exp(4'b1100, 2'd0);
      check("lr_pending", 32'(confirm_pending), 32'd0);
      check("lr_state", 32'(dbg_state), 32'(ST_BROWSE));

      // Inactivity timeout from screen 3
      press_exp(4'b0001, 2'd3);
      repeat (150) @(negedge clk);
      check("timeout_not_yet", 32'(screen_sel), 32'd3);
      exp_sel_q.push_back(2'd0);
      repeat (60) @(negedge clk);
      check("timeout_sel", 32'(screen_sel), 32'd0);
      check("timeout_screen_rst", 32'(screen_rst), 32'hE);

      // Asynchronous reset during CONFIRM on screen 2
      press_exp(4'b0010, 2'd1);
      press_exp(4'b0010, 2'd2);
      press(4'b1000, 5, 5);
      check("pre_reset_pending", 32'(confirm_pending), 32'd1);
      check("pre_reset_action_id", 32'(action_id), 32'd2);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("async_sel", 32'(screen_sel), 32'd0);
      check("async_screen_rst", 32'(screen_rst), 32'hF);
      check("async_pending", 32'(confirm_pending), 32'd0);
      check("async_action_go", 32'(action_go), 32'd0);
      check("async_action_id", 32'(action_id), 32'd0);
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      #1;
      check("rerelease_screen_rst", 32'(screen_rst), 32'hE);
      check("rerelease_state", 32'(dbg_state), 32'(ST_BROWSE));

      repeat (10) @(negedge clk);
      check("sel_queue_empty", 32'(exp_sel_q.size()), 32'd0);
      check("act_queue_empty", 32'(exp_act_q.size()), 32'd0);
      report();
      $finish;
   end

endmodule

// File: doc/atm_menu_ctrl.md
Name: atm_menu_ctrl

Overview:
- Top-level menu sequencer for the crypto ATM: debounces the four push-buttons, tracks the selected menu screen, and confirms the user's choice in two steps.
- Drives the select and per-screen restart lines that choose which instruction scroller feeds the seven-segment display.
- Issues a one-cycle action strobe to the transaction datapath (balance / withdraw / convert / exit).
- Returns to screen 0 after an inactivity timeout.

Parameters:
- DEBOUNCE_CYCLES, 1000000: number of consecutive cycles a synchronized button level must stay stable before it is accepted (10 ms at 100 MHz).
- TIMEOUT_CYCLES, 3000000000: number of cycles with no accepted press before the block forces a return to screen 0 (30 s).
- CONFIRM_CYCLES, 500000000: window in which the second BTNR must arrive to confirm (5 s).

Ports:
- clk  in  1  system clock, 100 MHz
- rst_n  in  1  asynchronous, active-low reset
- BTNU  in  1  raw button, previous screen
- BTND  in  1  raw button, next screen
- BTNL  in  1  raw button, cancel/back
- BTNR  in  1  raw button, select/confirm
- screen_sel  out  2  index of the screen routed to the display mux
- screen_rst  out  4  active-high reset, one bit per scroller
- confirm_pending  out  1  high while in CONFIRM state; display blinks
- action_go  out  1  one-cycle strobe, action requested
- action_id  out  2  screen index latched at the confirm; valid when action_go is high

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=BROWSE, screen_sel=0, screen_rst=4'b1111, confirm_pending=0, action_go=0, action_id=0.
  - All counters and synchronizers clear.
  - First cycle after release: screen_rst=4'b1110.
- Input conditioning, per button:
  - 2-flop synchronizer, then a debounce counter. The counter reloads on any level change and accepts the level when it reaches DEBOUNCE_CYCLES.
  - A rising edge of the accepted level produces a 1-cycle press pulse.
  - Latency from a stable raw press to the press pulse is 2 + DEBOUNCE_CYCLES + 1 cycles.
  - Glitches shorter than DEBOUNCE_CYCLES produce no pulse.
  - A held button produces exactly one pulse.
- Simultaneous pulses in the same cycle:
  - up+down together: ignored.
  - Priority among the rest: BTNL > BTNR > BTND > BTNU.
- State BROWSE:
  - BTND pulse: screen_sel+1, wrapping 3->0.
  - BTNU pulse: screen_sel-1, wrapping 0->3.
  - BTNR pulse: go to CONFIRM; action_id latches screen_sel.
  - BTNL pulse: screen_sel=0.
- State CONFIRM:
  - confirm_pending=1. BTNU and BTND are ignored.
  - BTNR pulse: go to COMMIT.
  - BTNL pulse, or CONFIRM_CYCLES elapsed: back to BROWSE with screen_sel unchanged.
- State COMMIT (one cycle): action_go=1, then unconditionally to BROWSE. screen_sel is unchanged.
- Screen restart:
  - screen_rst[i] = (i != screen_sel), registered.
  - When screen_sel changes, the new screen's bit is held 1 for exactly one extra cycle so its scroller restarts from the first character.
  - Exactly one bit is 0 at all other times outside reset.
- Inactivity timeout:
  - The counter clears on any accepted press and saturates at TIMEOUT_CYCLES.
  - On reaching TIMEOUT_CYCLES in BROWSE or CONFIRM: state=BROWSE, screen_sel=0 (with restart if it changed), confirm_pending=0, no action_go.
- A reset assertion during COMMIT suppresses action_go immediately.
- All outputs are registered. action_go is never high for two consecutive cycles.

Test Plan (bench overrides DEBOUNCE_CYCLES=4, CONFIRM_CYCLES=50, TIMEOUT_CYCLES=200):
- Reset release, then 4 BTND presses spaced 20 cycles apart -> screen_sel steps 1,2,3,0. On each change the new bit of screen_rst stays 1 for one extra cycle.
- BTNU from screen 0 -> screen_sel=3. A 2-cycle BTND glitch -> no change. Holding BTND for 100 cycles -> exactly one increment.
- On screen 2: BTNR, then BTNR 10 cycles later -> confirm_pending high between the presses; action_go high for exactly 1 cycle with action_id=2; state returns to BROWSE.
- On screen 1: BTNR, then no press -> confirm_pending drops after 50 cycles; no action_go; screen_sel=1. Repeat with BTNL as the cancel -> same result.
- BTNU and BTND asserted together -> screen_sel unchanged. BTNL and BTNR together in BROWSE -> screen_sel=0 and no CONFIRM.
- On screen 3 with no press for 200 cycles -> screen_sel=0 and screen_rst=4'b1110. Asserting rst_n low during CONFIRM -> all outputs go to reset values immediately, without waiting for a clock edge.
